// File: rtl/generic_fifo_pkg.sv
// Shared helpers for the width-ratio FIFO family: size derivation,
// configuration legality and wide-word slice ordering.
package generic_fifo_pkg;

  // Number of narrow entries addressed by a pointer of the given width.
  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << ptr_width;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
  function automatic int unsigned cnt_width(input int unsigned ptr_width);
    return ptr_width + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Legal configurations: power-of-2 ratio no larger than the array,
  // and an almost-full threshold that can actually be reached.
  function automatic bit cfg_ok(input int unsigned depth,
                                input int unsigned ratio,
                                input int unsigned af_level);
    return is_pow2(ratio) && (ratio <= depth) &&
           (af_level >= 1) && (af_level <= depth);
  endfunction

  // Which slice of the wide word is delivered k-th.
  function automatic int unsigned slice_sel(input int unsigned k,
                                            input int unsigned ratio,
                                            input bit          lsb_first);
    return lsb_first ? k : (ratio - 1 - k);
  endfunction

endpackage

// File: rtl/generic_fifo_ptr_ctrl.sv
// Pointer, occupancy and handshake control for a RATIO:1 width FIFO.
// Writes consume RATIO narrow entries, reads release one.
module generic_fifo_ptr_ctrl
  import generic_fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = 3,
  parameter int unsigned RATIO     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_valid,
  input  logic                 rd_ready,
  output logic                 wr_ready,
  output logic                 rd_valid,
  output logic                 wr_fire,
  output logic                 rd_fire,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic [PTR_WIDTH-1:0] rd_ptr,
  output logic [PTR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);
  localparam int unsigned CW    = cnt_width(PTR_WIDTH);

  localparam logic [CW-1:0]        RATIO_C  = CW'(RATIO);
  localparam logic [CW-1:0]        WR_LIMIT = CW'(DEPTH - RATIO);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  // RATIO == DEPTH truncates to a zero step, which is the correct modulo wrap.
  localparam logic [PTR_WIDTH-1:0] WR_STEP  = RATIO_C[PTR_WIDTH-1:0];
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  logic [CW-1:0] count_next;

  assign wr_ready = (count <= WR_LIMIT);
  assign rd_valid = (count != '0);
  // Flush wins over any coincident transfer, so neither side fires.
  assign wr_fire  = wr_valid && wr_ready && !flush;
  assign rd_fire  = rd_valid && rd_ready && !flush;

  // Net occupancy change from this cycle's transfers.
  always_comb begin
    count_next = count;
    if (wr_fire) count_next = count_next + RATIO_C;
    if (rd_fire) count_next = count_next - CNT_ONE;
  end

  // Pointer and occupancy registers with async reset and sync flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + WR_STEP;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

endmodule

// File: rtl/generic_2clk_gearbox_fifo_rf.sv
// Wide-in / narrow-out FWFT FIFO: one RATIO*DW word per write,
// one DW word per read, single clock.
module generic_2clk_gearbox_fifo_rf
  import generic_fifo_pkg::*;
#(
  parameter int unsigned DW        = 10,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned PTR_WIDTH = 3,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned AF_LEVEL  = (2 ** PTR_WIDTH) - RATIO
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [RATIO*DW-1:0] wrdata,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DW-1:0]       rddata,
  output logic [PTR_WIDTH:0]  fill_level,
  output logic                almost_full
);

  localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);
  localparam int unsigned CW    = cnt_width(PTR_WIDTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);

  if (!cfg_ok(DEPTH, RATIO, AF_LEVEL)) begin : g_cfg_err
    $error("generic_2clk_gearbox_fifo_rf: illegal RATIO/PTR_WIDTH/AF_LEVEL");
  end

  logic                 wr_fire;
  logic                 rd_fire;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]        count;
  logic [DW-1:0]        mem [DEPTH];

  generic_fifo_ptr_ctrl #(
    .PTR_WIDTH (PTR_WIDTH),
    .RATIO     (RATIO)
  ) u_ptr_ctrl (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_valid (wr_valid),
    .rd_ready (rd_ready),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .wr_fire  (wr_fire),
    .rd_fire  (rd_fire),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count)
  );

  // Storage: cleared on reset, RATIO slices scattered from wr_ptr on a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_fire) begin
      for (int unsigned k = 0; k < RATIO; k++)
        mem[wr_ptr + PTR_WIDTH'(k)] <= wrdata[slice_sel(k, RATIO, LSB_FIRST != 0)*DW +: DW];
    end
  end

  assign rddata      = mem[rd_ptr];
  assign fill_level  = count;
  assign almost_full = (count >= AF_C);

endmodule
